mem_access_unit: RTL and testbench

- MEM-stage data-memory access controller. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Takes a load/store from EX/MEM and runs a request/grant/response transaction on the data-memory bus.
- Stalls the pipeline until the access completes.
- Delivers the aligned, extended load word as dmDataOut for MEM/WB to capture.

---
 rtl/mem_pkg.sv | 61 ++++++
 rtl/mem_load_align.sv | 38 +++
 rtl/mem_access_unit.sv | 166 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage data-memory access unit.
//   - MemOp encoding (loads; stores reuse the low-size codes)
//   - access FSM state enum
//   - byte-enable lane constants
//   - size / sign / alignment helpers derived from the MemOp code
package mem_pkg;

  typedef enum logic [2:0] {
    MOP_LB  = 3'b000,
    MOP_LH  = 3'b001,
    MOP_LW  = 3'b010,
    MOP_LBU = 3'b100,
    MOP_LHU = 3'b101
  } mem_op_e;

  // Stores share the size field of the signed loads.
  localparam mem_op_e MOP_SB = MOP_LB;
  localparam mem_op_e MOP_SH = MOP_LH;
  localparam mem_op_e MOP_SW = MOP_LW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RSP,
    ST_DRAIN,
    ST_DONE
  } mau_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } mem_size_e;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic mem_size_e op_size(input logic [2:0] op);
    case (op[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  // Bit 2 of the op selects zero-extension.
  function automatic logic op_signed(input logic [2:0] op);
    return ~op[2];
  endfunction

  function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
    case (op_size(op))
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return |addr_lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: combinational load-lane select and extension.
//   rdata   - raw 32-bit bus read word
//   addr_lo - byte offset of the access within the word
//   op      - MemOp code (size and signedness)
//   result  - selected lane, sign- or zero-extended to 32 bits
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  op,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  always_comb begin
    byte_sel = '0;
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = '0;
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    sext     = op_signed(op);

    case (op_size(op))
      SZ_BYTE: result = {{24{sext & byte_sel[7]}}, byte_sel};
      SZ_HALF: result = {{16{sext & half_sel[15]}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access controller.
//   Clk, Rst_n         - clock, synchronous active-low reset
//   MemR_EX/MemW_EX    - load / store request from EX/MEM
//   MemOp_EX           - access size/sign code
//   Addr_EX            - byte address
//   StoreData_EX       - store data (rt)
//   Flush              - kill the current access
//   bus_*              - request/grant/response data-memory bus
//   dmDataOut          - aligned, extended load result (registered)
//   MemStall           - pipeline freeze while an access is in flight
//   MemDone            - access completes this cycle
//   AddrErr            - misaligned access flagged in the completion cycle
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              MemR_EX,
  input  logic              MemW_EX,
  input  logic [2:0]        MemOp_EX,
  input  logic [ADDR_W-1:0] Addr_EX,
  input  logic [DATA_W-1:0] StoreData_EX,
  input  logic              Flush,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] dmDataOut,
  output logic              MemStall,
  output logic              MemDone,
  output logic              AddrErr
);

  mau_state_e state_q, state_d;

  logic              access;
  logic              take;
  logic              misal;
  logic [2:0]        op_q;
  logic [1:0]        alo_q;
  logic              err_q;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_wdata;
  logic [DATA_W-1:0] load_word;

  assign access = MemR_EX | MemW_EX;
  // A flushed instruction never starts an access.
  assign take   = access & ~Flush;
  assign misal  = op_misaligned(MemOp_EX, Addr_EX[1:0]);

  mem_load_align u_align (
    .rdata   (bus_rdata),
    .addr_lo (alo_q),
    .op      (op_q),
    .result  (load_word)
  );

  // Store lane placement; loads request the whole word.
  always_comb begin
    st_be    = BE_WORD;
    st_wdata = '0;
    if (MemW_EX) begin
      case (op_size(MemOp_EX))
        SZ_BYTE: begin
          st_be    = BE_BYTE0 << Addr_EX[1:0];
          st_wdata = {4{StoreData_EX[7:0]}};
        end
        SZ_HALF: begin
          st_be    = Addr_EX[1] ? BE_HALF_HI : BE_HALF_LO;
          st_wdata = {2{StoreData_EX[15:0]}};
        end
        default: begin
          st_be    = BE_WORD;
          st_wdata = StoreData_EX;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (take) state_d = misal ? ST_DONE : ST_REQ;
      ST_REQ: begin
        // A granted store has committed even if flushed; a granted load
        // still owes a response that must be absorbed.
        if (bus_gnt)    state_d = bus_we ? ST_DONE : (Flush ? ST_DRAIN : ST_RSP);
        else if (Flush) state_d = ST_IDLE;
      end
      ST_RSP: begin
        if (Flush)           state_d = bus_rvalid ? ST_IDLE : ST_DRAIN;
        else if (bus_rvalid) state_d = ST_DONE;
      end
      ST_DRAIN: if (bus_rvalid) state_d = ST_IDLE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    MemStall = access & (state_q != ST_DONE) & ~Flush;
    MemDone  = (state_q == ST_DONE);
    AddrErr  = (state_q == ST_DONE) & err_q;
  end

  // Bus request fields and load result.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      dmDataOut <= '0;
      op_q      <= '0;
      alo_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (take) begin
            if (misal) begin
              err_q     <= 1'b1;
              dmDataOut <= '0;
            end else begin
              err_q     <= 1'b0;
              op_q      <= MemOp_EX;
              alo_q     <= Addr_EX[1:0];
              bus_req   <= 1'b1;
              bus_we    <= MemW_EX;
              bus_addr  <= {Addr_EX[ADDR_W-1:2], 2'b00};
              bus_be    <= st_be;
              bus_wdata <= st_wdata;
            end
          end
        end
        ST_REQ: begin
          if (bus_gnt || Flush) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
          end
        end
        ST_RSP: begin
          if (bus_rvalid && !Flush) dmDataOut <= load_word;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        MemR_EX, MemW_EX;
  logic [2:0]  MemOp_EX;
  logic [31:0] Addr_EX, StoreData_EX;
  logic        Flush;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;
  logic [31:0] dmDataOut;
  logic        MemStall, MemDone, AddrErr;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .MemR_EX(MemR_EX), .MemW_EX(MemW_EX),
    .MemOp_EX(MemOp_EX), .Addr_EX(Addr_EX), .StoreData_EX(StoreData_EX),
    .Flush(Flush), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .dmDataOut(dmDataOut),
    .MemStall(MemStall), .MemDone(MemDone), .AddrErr(AddrErr)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [31:0] dm;
    logic        err;
  } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];
  bus_exp_t  mb;
  done_exp_t md;
  logic [31:0] last_dm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] op);
    if (op[1:0] == 2'b00) return 1;
    if (op[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input int a, input logic [31:0] w);
    int     n;
    longint span, v;
    n    = nbytes(op);
    span = longint'(1) << (8 * n);
    v    = (longint'(w) >> (8 * a)) % span;
    if (!op[2] && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_be(input int a, input int n);
    logic [3:0] b;
    for (int k = 0; k < 4; k++) b[k] = (k >= a) && (k < a + n);
    return b;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] sd, input int n);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = sd[8*(k % n) +: 8];
    return r;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge Clk) begin
    if (Rst_n) begin
      if (bus_req) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected_req: got req=1 required req=0 at %0t", $time);
        end else begin
          mb = bus_q[0];
          check("bus_we", {31'd0, bus_we}, {31'd0, mb.we});
          check("bus_addr", bus_addr, mb.addr);
          check("bus_be", {28'd0, bus_be}, {28'd0, mb.be});
          if (mb.we) check("bus_wdata", bus_wdata, mb.wdata);
          if (bus_gnt) void'(bus_q.pop_front());
        end
      end
      if (MemDone) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got MemDone=1 required 0 at %0t", $time);
        end else begin
          md = done_q.pop_front();
          check("dmDataOut", dmDataOut, md.dm);
          check("AddrErr", {31'd0, AddrErr}, {31'd0, md.err});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    bus_q.delete();
    done_q.delete();
    last_dm = '0;
  endtask

  task automatic run_access(input bit st, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] sd, input logic [31:0] rd,
                            input int gd, input int rvd);
    int  n, a, exp_stall, stalls, req_seen, gnt_at, cyc;
    bit  mis, rv_done, done_seen, fin;
    n = nbytes(op);
    a = int'(addr[1:0]);
    mis = (a % n) != 0;
    if (mis) begin
      last_dm = '0;
      done_q.push_back('{dm: 32'd0, err: 1'b1});
      exp_stall = 1;
    end else begin
      bus_q.push_back('{we: st, addr: {addr[31:2], 2'b00},
                        be: st ? ref_be(a, n) : 4'b1111,
                        wdata: ref_wdata(sd, n)});
      if (!st) last_dm = ref_load(op, a, rd);
      done_q.push_back('{dm: last_dm, err: 1'b0});
      exp_stall = st ? gd + 2 : gd + rvd + 3;
    end
    MemR_EX = !st; MemW_EX = st; MemOp_EX = op; Addr_EX = addr; StoreData_EX = sd;
    stalls = 0; req_seen = 0; gnt_at = -1; cyc = 0;
    rv_done = 0; done_seen = 0; fin = 0;
    while (!fin && cyc < 100) begin
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
      if (bus_req) begin
        if (req_seen == gd) begin bus_gnt = 1'b1; gnt_at = cyc; end
        req_seen++;
      end
      if (!st && !mis && gnt_at >= 0 && !rv_done && cyc == gnt_at + 1 + rvd) begin
        bus_rvalid = 1'b1; bus_rdata = rd; rv_done = 1;
      end
      @(negedge Clk);
      if (MemStall) stalls++;
      if (MemDone) done_seen = 1;
      tick();
      cyc++;
      if (done_seen) fin = 1;
    end
    MemR_EX = 1'b0; MemW_EX = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    if (!fin) begin
      checks++; errors++;
      $display("FAIL access_timeout: got no MemDone required MemDone within 100 cycles (addr 0x%08h)", addr);
      do_reset();
    end else begin
      check("stall_cycles", stalls, exp_stall);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test required finish before 1ms");
    $fatal(1);
  end

  initial begin
    logic [2:0] lops [5];
    logic [2:0] sops [3];
    bit         st;
    logic [2:0] op;
    lops = '{MOP_LB, MOP_LH, MOP_LW, MOP_LBU, MOP_LHU};
    sops = '{MOP_SB, MOP_SH, MOP_SW};

    Rst_n = 1'b0; MemR_EX = 0; MemW_EX = 0; MemOp_EX = '0; Addr_EX = '0;
    StoreData_EX = '0; Flush = 0; bus_gnt = 0; bus_rvalid = 0; bus_rdata = '0;
    last_dm = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_bus_we", {31'd0, bus_we}, 32'd0);
    check("rst_bus_be", {28'd0, bus_be}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_dmDataOut", dmDataOut, 32'd0);
    check("rst_MemDone", {31'd0, MemDone}, 32'd0);
    check("rst_AddrErr", {31'd0, AddrErr}, 32'd0);
    Rst_n = 1'b1;
    tick();

    // Directed accesses
    run_access(0, MOP_LW,  32'h0000_1000, '0, 32'hDEAD_BEEF, 0, 0);
    run_access(0, MOP_LB,  32'h0000_1003, '0, 32'h8011_2233, 0, 0);
    run_access(0, MOP_LBU, 32'h0000_1003, '0, 32'h8011_2233, 0, 0);
    run_access(0, MOP_LH,  32'h0000_1002, '0, 32'h8011_2233, 0, 0);
    run_access(1, MOP_SB,  32'h0000_2001, 32'h0000_00A5, '0, 2, 0);
    run_access(0, MOP_LW,  32'h0000_3002, '0, 32'h1111_1111, 0, 0);
    run_access(0, MOP_LHU, 32'h0000_3006, '0, 32'hF00D_0000, 1, 2);
    run_access(1, MOP_SH,  32'h0000_3002, 32'h1234_BEEF, '0, 0, 0);

    // Flush while waiting for grant
    bus_q.push_back('{we: 1'b0, addr: 32'h0000_4000, be: 4'b1111, wdata: '0});
    MemR_EX = 1; MemOp_EX = MOP_LW; Addr_EX = 32'h0000_4000;
    tick(); tick();
    Flush = 1;
    @(negedge Clk);
    check("flush_req_stall", {31'd0, MemStall}, 32'd0);
    tick();
    Flush = 0; MemR_EX = 0;
    bus_q.delete();
    @(negedge Clk);
    check("flush_req_drop", {31'd0, bus_req}, 32'd0);
    tick(); tick();

    // Flush during response wait: returned data must be discarded
    run_access(0, MOP_LW, 32'h0000_5000, '0, 32'h1234_5678, 0, 0);
    bus_q.push_back('{we: 1'b0, addr: 32'h0000_5004, be: 4'b1111, wdata: '0});
    MemR_EX = 1; MemOp_EX = MOP_LW; Addr_EX = 32'h0000_5004;
    tick();
    bus_gnt = 1;
    tick();
    bus_gnt = 0; Flush = 1;
    @(negedge Clk);
    check("flush_rsp_stall", {31'd0, MemStall}, 32'd0);
    tick();
    Flush = 0; MemR_EX = 0;
    tick(); tick();
    bus_rvalid = 1; bus_rdata = 32'hCAFE_F00D;
    tick();
    bus_rvalid = 0;
    @(negedge Clk);
    check("drain_keeps_dm", dmDataOut, last_dm);
    tick();
    run_access(0, MOP_LB, 32'h0000_5009, '0, 32'h0000_7F00, 0, 1);

    // Reset during response wait; a late rvalid must be ignored
    bus_q.push_back('{we: 1'b0, addr: 32'h0000_6000, be: 4'b1111, wdata: '0});
    MemR_EX = 1; MemOp_EX = MOP_LW; Addr_EX = 32'h0000_6000;
    tick();
    bus_gnt = 1;
    tick();
    bus_gnt = 0; Rst_n = 0; MemR_EX = 0;
    tick();
    Rst_n = 1;
    bus_q.delete(); done_q.delete(); last_dm = '0;
    check("rstmid_bus_req", {31'd0, bus_req}, 32'd0);
    check("rstmid_bus_be", {28'd0, bus_be}, 32'd0);
    check("rstmid_bus_addr", bus_addr, 32'd0);
    check("rstmid_dm", dmDataOut, 32'd0);
    check("rstmid_done", {31'd0, MemDone}, 32'd0);
    bus_rvalid = 1; bus_rdata = 32'hFFFF_FFFF;
    tick();
    bus_rvalid = 0;
    @(negedge Clk);
    check("late_rvalid_dm", dmDataOut, 32'd0);
    tick();
    run_access(1, MOP_SW, 32'h0000_7000, 32'h0BAD_F00D, '0, 1, 0);

    // Randomized accesses
    for (int i = 0; i < 60; i++) begin
      st = $urandom_range(0, 2) == 0;
      op = st ? sops[$urandom_range(0, 2)] : lops[$urandom_range(0, 4)];
      run_access(st, op, $urandom, $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) tick();
    end

    tick(); tick();
    check("bus_q_drained", bus_q.size(), 32'd0);
    check("done_q_drained", done_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
